// File: rtl/fifo_flow_pkg.sv
// Shared types and sizing constants for the FIFO flow controller.
package fifo_flow_pkg;
   typedef enum logic {R_EMPTY = 1'b0, R_FULL = 1'b1} rd_state_e;

   localparam int ADDR_WIDTH_DEF = 3;
   localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;
   localparam int LVL_W          = ADDR_WIDTH_DEF + 1;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/fifo_flow_if.sv
// Handshake and datapath bundle between producer/consumer/datapath and the controller.
interface fifo_flow_if
   import fifo_flow_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int PAR_READ   = 1
);
   logic                           wr_valid;
   logic                           wr_ready;
   logic                           rd_valid;
   logic                           rd_ready;
   logic [DATA_WIDTH*PAR_READ-1:0] rd_data;
   logic [DATA_WIDTH*PAR_READ-1:0] fifo_dout;
   logic                           empty;
   logic                           full;
   logic                           wbuff;
   logic                           enr;

   modport slave (
      input  wr_valid, rd_ready, fifo_dout, empty, full,
      output wr_ready, rd_valid, rd_data, wbuff, enr
   );

   modport master (
      output wr_valid, rd_ready, fifo_dout, empty, full,
      input  wr_ready, rd_valid, rd_data, wbuff, enr
   );
endinterface

// File: rtl/fifo_level_tracker.sv
// Saturating occupancy counter for the datapath with a registered check
// against the datapath's own empty/full flags.
module fifo_level_tracker
   import fifo_flow_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int PAR_WRITE  = 1,
   parameter int PAR_READ   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wbuff,
   input  logic              enr,
   input  logic              empty,
   input  logic              full,
   input  logic              clr_err,
   output logic [ADDR_WIDTH:0] level,
   output logic              lvl_err
);
   localparam int DEP = depth_of(ADDR_WIDTH);
   localparam int LW  = ADDR_WIDTH + 1;
   localparam logic [LW-1:0] RD_TH   = LW'(PAR_READ);
   localparam logic [LW-1:0] FULL_TH = LW'(DEP - PAR_WRITE);
   localparam logic [LW-1:0] LVL_MAX = LW'(DEP);

   logic [LW-1:0] level_q, level_d;
   logic          lvl_err_q, lvl_err_d;
   logic          sat;
   logic          mismatch;
   int            nxt;

   always_comb begin
      level_d   = level_q;
      sat       = 1'b0;
      lvl_err_d = lvl_err_q;
      nxt = int'(level_q) + (wbuff ? PAR_WRITE : 0) - (enr ? PAR_READ : 0);
      // Clamp instead of wrapping so level stays meaningful after a datapath fault.
      if (nxt > DEP) begin
         level_d = LVL_MAX;
         sat     = 1'b1;
      end else if (nxt < 0) begin
         level_d = '0;
         sat     = 1'b1;
      end else begin
         level_d = LW'(nxt);
      end

      mismatch = (empty  && (level_q >= RD_TH))   ||
                 (!empty && (level_q <  RD_TH))   ||
                 (full   && (level_q <= FULL_TH)) ||
                 (!full  && (level_q >  FULL_TH));

      if (clr_err)         lvl_err_d = 1'b0;
      if (mismatch || sat) lvl_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q   <= '0;
         lvl_err_q <= 1'b0;
      end else begin
         level_q   <= level_d;
         lvl_err_q <= lvl_err_d;
      end
   end

   assign level   = level_q;
   assign lvl_err = lvl_err_q;
endmodule

// File: rtl/fifo_flow_ctrl.sv
// Valid/ready sequencer for the circular FIFO datapath: write strobe,
// two-state read FSM feeding a registered output word, and debug flags.
module fifo_flow_ctrl
   import fifo_flow_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int PAR_WRITE  = 1,
   parameter int PAR_READ   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_flow_if.slave          bus,
   output logic [ADDR_WIDTH:0] level,
   output logic                wr_proto_err,
   output logic                lvl_err,
   input  logic                clr_err
);
   localparam int RW = DATA_WIDTH * PAR_READ;

   rd_state_e     state_q, state_d;
   logic [RW-1:0] rd_data_q, rd_data_d;
   logic          wr_pend_q, wr_pend_d;
   logic          perr_q, perr_d;
   logic          enr_c;
   logic          wbuff_g, enr_g;

   always_comb begin
      state_d   = state_q;
      rd_data_d = rd_data_q;
      enr_c     = 1'b0;
      case (state_q)
         R_EMPTY: begin
            if (!bus.empty) begin
               enr_c     = 1'b1;
               rd_data_d = bus.fifo_dout;
               state_d   = R_FULL;
            end
         end
         R_FULL: begin
            if (bus.rd_ready) begin
               if (!bus.empty) begin
                  enr_c     = 1'b1;
                  rd_data_d = bus.fifo_dout;
               end else begin
                  state_d = R_EMPTY;
               end
            end
         end
         default: state_d = R_EMPTY;
      endcase

      // A stalled offer must be held until taken; dropping it is flagged.
      wr_pend_d = bus.wr_valid & bus.full;
      perr_d    = perr_q;
      if (clr_err)                    perr_d = 1'b0;
      if (wr_pend_q && !bus.wr_valid) perr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= R_EMPTY;
         rd_data_q <= '0;
         wr_pend_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
         wr_pend_q <= wr_pend_d;
         perr_q    <= perr_d;
      end
   end

   assign wbuff_g      = bus.wr_valid & ~bus.full & rst_n;
   assign enr_g        = enr_c & rst_n;
   assign bus.wr_ready = ~bus.full;
   assign bus.wbuff    = wbuff_g;
   assign bus.enr      = enr_g;
   assign bus.rd_valid = (state_q == R_FULL);
   assign bus.rd_data  = rd_data_q;
   assign wr_proto_err = perr_q;

   fifo_level_tracker #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PAR_WRITE  (PAR_WRITE),
      .PAR_READ   (PAR_READ)
   ) u_lvl (
      .clk     (clk),
      .rst_n   (rst_n),
      .wbuff   (wbuff_g),
      .enr     (enr_g),
      .empty   (bus.empty),
      .full    (bus.full),
      .clr_err (clr_err),
      .level   (level),
      .lvl_err (lvl_err)
   );
endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Bench: behavioural 8-deep datapath, scoreboard on the read side,
// vector table for the fill/protocol phase plus hand-written sequences.
module tb_fifo_flow_ctrl;
   import fifo_flow_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_err;
   logic [3:0]  level;
   logic        wr_proto_err, lvl_err;
   logic [15:0] din;
   logic        force_empty;

   int total = 0;
   int bad   = 0;

   fifo_flow_if #(.DATA_WIDTH(16), .PAR_READ(1)) bus ();

   fifo_flow_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .PAR_WRITE(1), .PAR_READ(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .level        (level),
      .wr_proto_err (wr_proto_err),
      .lvl_err      (lvl_err),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   // datapath model
   logic [15:0] mem [8];
   logic [2:0]  wp, rp;
   int          cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0; rp <= '0; cnt <= 0;
      end else begin
         if (bus.wbuff) begin mem[wp] <= din; wp <= wp + 3'd1; end
         if (bus.enr) rp <= rp + 3'd1;
         cnt <= cnt + (bus.wbuff ? 1 : 0) - (bus.enr ? 1 : 0);
      end
   end

   assign bus.fifo_dout = mem[rp];
   assign bus.empty     = (cnt == 0) || force_empty;
   assign bus.full      = (cnt == DEPTH);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // scoreboard
   logic [15:0] sb [$];
   logic [15:0] sb_e;

   always @(negedge clk) begin
      if (!rst_n) sb.delete();
      else begin
         if (bus.rd_valid && bus.rd_ready) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL sb_underflow act=%0h exp=none", bus.rd_data);
            end else begin
               sb_e = sb.pop_front();
               chk("sb_rd_data", 32'(bus.rd_data), 32'(sb_e));
            end
         end
         if (bus.wbuff) sb.push_back(din);
      end
   end

   typedef struct {
      logic        wv, rr;
      logic [15:0] d;
      logic        e_wrdy, e_wb, e_enr, e_rv;
      logic [15:0] e_rd;
      logic [3:0]  e_lvl;
      logic        e_perr;
   } vec_t;

   vec_t vt [13];

   function automatic vec_t mk(logic wv, logic rr, logic [15:0] d, logic wrdy, logic wb,
                               logic en, logic rv, logic [15:0] rd, logic [3:0] lv, logic pe);
      vec_t v;
      v.wv = wv; v.rr = rr; v.d = d; v.e_wrdy = wrdy; v.e_wb = wb; v.e_enr = en;
      v.e_rv = rv; v.e_rd = rd; v.e_lvl = lv; v.e_perr = pe;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   initial begin
      // fill with rd_ready=0: 1111 goes to the output reg, 2222..9999 fill the datapath
      vt[0]  = mk(1, 0, 16'h1111, 1, 1, 0, 0, 16'h0000, 4'd0, 0);
      vt[1]  = mk(1, 0, 16'h2222, 1, 1, 1, 0, 16'h0000, 4'd1, 0);
      vt[2]  = mk(1, 0, 16'h3333, 1, 1, 0, 1, 16'h1111, 4'd1, 0);
      vt[3]  = mk(1, 0, 16'h4444, 1, 1, 0, 1, 16'h1111, 4'd2, 0);
      vt[4]  = mk(1, 0, 16'h5555, 1, 1, 0, 1, 16'h1111, 4'd3, 0);
      vt[5]  = mk(1, 0, 16'h6666, 1, 1, 0, 1, 16'h1111, 4'd4, 0);
      vt[6]  = mk(1, 0, 16'h7777, 1, 1, 0, 1, 16'h1111, 4'd5, 0);
      vt[7]  = mk(1, 0, 16'h8888, 1, 1, 0, 1, 16'h1111, 4'd6, 0);
      vt[8]  = mk(1, 0, 16'h9999, 1, 1, 0, 1, 16'h1111, 4'd7, 0);
      vt[9]  = mk(1, 0, 16'hAAAA, 0, 0, 0, 1, 16'h1111, 4'd8, 0);
      vt[10] = mk(1, 0, 16'hAAAA, 0, 0, 0, 1, 16'h1111, 4'd8, 0);
      vt[11] = mk(0, 0, 16'hAAAA, 0, 0, 0, 1, 16'h1111, 4'd8, 0);
      vt[12] = mk(0, 0, 16'hAAAA, 0, 0, 0, 1, 16'h1111, 4'd8, 1);

      rst_n = 1'b1; clr_err = 1'b0; force_empty = 1'b0;
      bus.wr_valid = 1'b1; bus.rd_ready = 1'b1; din = 16'hDEAD;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data",  32'(bus.rd_data), 0);
      chk("rst_level",    32'(level), 0);
      chk("rst_wbuff",    32'(bus.wbuff), 0);
      chk("rst_enr",      32'(bus.enr), 0);
      chk("rst_perr",     32'(wr_proto_err), 0);
      chk("rst_lvl_err",  32'(lvl_err), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;

      // single write, consumer stalled
      cyc(); bus.wr_valid = 1'b1; din = 16'hA5A5;
      @(negedge clk); chk("sw_wbuff", 32'(bus.wbuff), 1);
      cyc(); bus.wr_valid = 1'b0;
      @(negedge clk); chk("sw_enr", 32'(bus.enr), 1); chk("sw_rv_early", 32'(bus.rd_valid), 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         @(negedge clk);
         chk("sw_rv", 32'(bus.rd_valid), 1);
         chk("sw_rd_data", 32'(bus.rd_data), 32'h0000A5A5);
         chk("sw_level", 32'(level), 0);
         chk("sw_enr_stall", 32'(bus.enr), 0);
      end
      cyc(); bus.rd_ready = 1'b1;
      cyc(); bus.rd_ready = 1'b0;
      @(negedge clk); chk("sw_drained", 32'(bus.rd_valid), 0);

      // table: fill to full, then drop a stalled offer
      for (int i = 0; i < 13; i++) begin
         cyc(); bus.wr_valid = vt[i].wv; bus.rd_ready = vt[i].rr; din = vt[i].d;
         @(negedge clk);
         chk($sformatf("v%0d_wr_ready", i), 32'(bus.wr_ready), 32'(vt[i].e_wrdy));
         chk($sformatf("v%0d_wbuff", i),    32'(bus.wbuff),    32'(vt[i].e_wb));
         chk($sformatf("v%0d_enr", i),      32'(bus.enr),      32'(vt[i].e_enr));
         chk($sformatf("v%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vt[i].e_rv));
         if (vt[i].e_rv) chk($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(vt[i].e_rd));
         chk($sformatf("v%0d_level", i),    32'(level),        32'(vt[i].e_lvl));
         chk($sformatf("v%0d_perr", i),     32'(wr_proto_err), 32'(vt[i].e_perr));
         chk($sformatf("v%0d_lvl_err", i),  32'(lvl_err),      0);
      end

      // clear the protocol flag
      cyc(); clr_err = 1'b1;
      @(negedge clk); chk("clr_perr_before", 32'(wr_proto_err), 1);
      cyc(); clr_err = 1'b0;
      @(negedge clk); chk("clr_perr_after", 32'(wr_proto_err), 0);
      chk("clr_level_full", 32'(level), 8);

      // drain the nine stored words in order
      cyc(); bus.rd_ready = 1'b1;
      repeat (11) cyc();
      @(negedge clk);
      chk("drain_level", 32'(level), 0);
      chk("drain_rv", 32'(bus.rd_valid), 0);

      // streaming both sides
      for (int i = 0; i < 20; i++) begin
         cyc(); bus.wr_valid = 1'b1; bus.rd_ready = 1'b1; din = 16'h0100 + 16'(i);
         @(negedge clk);
         chk("st_lvl_le1", 32'(level <= 4'd1), 1);
         chk("st_wr_ready", 32'(bus.wr_ready), 1);
         if (i >= 2) chk("st_rv", 32'(bus.rd_valid), 1);
      end
      chk("st_perr", 32'(wr_proto_err), 0);
      chk("st_lvl_err", 32'(lvl_err), 0);

      // reset with traffic active
      cyc(); rst_n = 1'b0;
      #1;
      chk("mrst_rd_valid", 32'(bus.rd_valid), 0);
      chk("mrst_rd_data",  32'(bus.rd_data), 0);
      chk("mrst_level",    32'(level), 0);
      chk("mrst_wbuff",    32'(bus.wbuff), 0);
      chk("mrst_enr",      32'(bus.enr), 0);
      cyc(); rst_n = 1'b1; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;

      // consistency: level 3 with empty forced high
      for (int i = 0; i < 4; i++) begin
         cyc(); bus.wr_valid = 1'b1; din = 16'h0C00 + 16'(i);
      end
      cyc(); bus.wr_valid = 1'b0;
      @(negedge clk); chk("cc_level", 32'(level), 3);
      cyc(); force_empty = 1'b1;
      @(negedge clk); chk("cc_lvl_err_before", 32'(lvl_err), 0);
      cyc(); force_empty = 1'b0;
      @(negedge clk); chk("cc_lvl_err_set", 32'(lvl_err), 1);
      repeat (2) cyc();
      @(negedge clk); chk("cc_lvl_err_sticky", 32'(lvl_err), 1);
      cyc(); clr_err = 1'b1;
      cyc(); clr_err = 1'b0;
      @(negedge clk); chk("cc_lvl_err_clr", 32'(lvl_err), 0);
      chk("cc_perr", 32'(wr_proto_err), 0);

      cyc(); bus.rd_ready = 1'b1;
      repeat (8) cyc();
      @(negedge clk);
      chk("final_sb_empty", 32'(sb.size()), 0);
      chk("final_level", 32'(level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
- Sequences the parallel-width circular FIFO datapath (write strobe `wbuff`, read advance `enr`, status `empty`/`full`).
- Exposes valid/ready handshakes on the producer and consumer sides.
- Registers the datapath's combinational read word into an output stage, so consumer data is glitch-free and stable while stalled.
- Tracks occupancy independently and flags protocol and consistency errors for debug.

Parameters:
- DATA_WIDTH, 16: bits per word.
- ADDR_WIDTH, 3: datapath address bits; depth = 2^ADDR_WIDTH.
- PAR_WRITE, 1: words written per `wbuff` strobe.
- PAR_READ, 1: words consumed per `enr` strobe.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  producer has PAR_WRITE words on the datapath `data_in`.
- wr_ready  output  1  controller can accept a write this cycle.
- rd_valid  output  1  rd_data holds a valid read group.
- rd_ready  input  1  consumer takes rd_data this cycle.
- rd_data  output  DATA_WIDTH*PAR_READ  registered read group.
- fifo_dout  input  DATA_WIDTH*PAR_READ  datapath `data_out`.
- empty  input  1  datapath empty flag.
- full  input  1  datapath full flag.
- wbuff  output  1  datapath write strobe.
- enr  output  1  datapath read-pointer advance.
- level  output  ADDR_WIDTH+1  words currently held in the datapath (excludes the output register).
- wr_proto_err  output  1  sticky: producer withdrew wr_valid before acceptance.
- lvl_err  output  1  sticky: level disagrees with empty/full.
- clr_err  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst_n low, asynchronous): rd_valid=0, rd_data=0, level=0, both sticky flags=0, read FSM=R_EMPTY. wbuff and enr are forced 0 while rst_n is low.
- Reset applies at the system level to datapath and controller together. A reset mid-transfer discards the word in the output register.
- Write side (combinational):
  - wr_ready = !full.
  - wbuff = wr_valid & wr_ready.
  - There is no write latency beyond the datapath's own clock edge.
- Read FSM, states R_EMPTY and R_FULL:
  - R_EMPTY:
    - If !empty: enr=1, rd_data<=fifo_dout, go to R_FULL.
    - Else: enr=0, stay.
  - R_FULL:
    - If rd_ready & !empty: enr=1, rd_data<=fifo_dout, stay. This sustains one group per cycle.
    - If rd_ready & empty: enr=0, go to R_EMPTY.
    - If !rd_ready: enr=0, rd_data holds, stay.
  - rd_valid = (state==R_FULL).
- Latency: a group written at edge T gives empty=0 after T, enr=1 in cycle T+1, and rd_valid=1 after edge T+1.
  - Minimum write-to-rd_valid latency is 2 edges.
  - Throughput is 1 group/cycle on both sides when neither side stalls.
- Level:
  - level <= level + PAR_WRITE·wbuff − PAR_READ·enr, using ADDR_WIDTH+1-bit unsigned arithmetic.
  - Simultaneous wbuff and enr apply both terms in the same cycle.
  - level never wraps. A computed value above 2^ADDR_WIDTH or below 0 saturates and sets lvl_err.
- Consistency check, registered: lvl_err is set when any of these holds:
  - empty=1 with level≥PAR_READ;
  - empty=0 with level<PAR_READ;
  - full=1 with level≤2^ADDR_WIDTH−PAR_WRITE;
  - full=0 with level>2^ADDR_WIDTH−PAR_WRITE.
- wr_proto_err is set when wr_valid=1 & wr_ready=0 in cycle N and wr_valid=0 in cycle N+1.
- clr_err=1 clears both sticky flags on the next edge. A flag set condition in the same cycle wins.
- Pointer wrap-around is owned by the datapath. The controller only needs level modulo-free, which holds because level saturates.

Decomposition:
- Package fifo_flow_pkg holds:
  - the read-state enum {R_EMPTY, R_FULL};
  - localparams DEPTH = 2^ADDR_WIDTH and LVL_W = ADDR_WIDTH+1.
- Sub-module fifo_level_tracker holds the level register, saturation logic and the lvl_err consistency check. Inputs: wbuff, enr, empty, full, clr_err.
- Top level contains the read FSM, output register, write handshake and wr_proto_err.

Test Plan (defaults: DEPTH=8, PAR=1):
- Reset: rst_n=0 with traffic active → rd_valid=0, level=0, wbuff=enr=0, rd_data=0 immediately, no clock edge required.
- Single write 0xA5A5 at edge T, rd_ready=0 → enr=1 in cycle T+1; rd_valid=1 with rd_data=0xA5A5 after T+1, held stable while stalled; level=0.
- Fill with rd_ready=0, data 0x1111..0x9999 → 9 words accepted (1 in output register, 8 in datapath); wr_ready=0 and level=8 thereafter; 10th word not written.
- Stream with wr_valid=1, rd_ready=1 for 20 cycles, incrementing data → rd_data sequence in order, one per cycle after 2-cycle fill latency; level stays ≤1; no error flags.
- Protocol error: wr_valid=1 while full, dropped next cycle → wr_proto_err=1. Then clr_err pulse → 0 after one edge.
- Consistency: force empty=1 while level=3 → lvl_err=1 on next edge; stays set until clr_err.
